mem_bus_arbiter: RTL and testbench

//  Shares the single synchronous RAM port between NUM_REQ requesters: 0=CPU fetch/load/store, 1=DMA, 2=IO.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/mem_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : cpu_pkg                                                         |
// | Purpose  : Shared types and constants for the memory bus arbiter slice.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    // Arbiter FSM encoding; explicit 2-bit width and fixed codes
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    // Requester indices on the shared RAM port
    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;
    localparam int REQ_IO  = 2;

    // Bits needed to hold 0..n-1, never less than one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                      |
// | Purpose  : Combinational round-robin pick: first asserted request at or   |
// |            above the pointer, wrapping around; one-hot and index outputs. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic               o_valid,
    output logic [NUM_REQ-1:0] o_win_oh,
    output logic [PTR_W-1:0]   o_win_idx
);

    localparam logic [PTR_W:0] c_num_req = (PTR_W + 1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic [PTR_W-1:0]     w_off;
    logic [PTR_W:0]       w_sum;

    // Rotating the doubled vector puts the pointer's requester at bit 0
    assign w_req_dbl = {i_req, i_req};
    assign w_req_rot = w_req_dbl[i_rr_ptr +: NUM_REQ];

    // Lowest set bit of the rotated vector is the distance to the winner
    always_comb begin
        o_valid = 1'b0;
        w_off   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_valid && w_req_rot[k]) begin
                o_valid = 1'b1;
                w_off   = PTR_W'(k);
            end
        end
    end

    // Undo the rotation with a modulo-NUM_REQ add
    assign w_sum     = {1'b0, i_rr_ptr} + {1'b0, w_off};
    assign o_win_idx = (w_sum >= c_num_req) ? PTR_W'(w_sum - c_num_req) : w_sum[PTR_W-1:0];
    assign o_win_oh  = o_valid ? (NUM_REQ'(1) << o_win_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_bus_arbiter                                                 |
// | Purpose  : Shares one synchronous RAM port among NUM_REQ requesters with  |
// |            round-robin grant, locked bursts and one transfer in flight.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_bus_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset_cycle,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int c_ptr_w   = clog2_min1(NUM_REQ);
    localparam int c_burst_w = clog2_min1(MAX_BURST);

    // Last beat index allowed under lock; with MAX_BURST=1 no extra beat is possible
    localparam logic [c_burst_w-1:0] c_burst_last = c_burst_w'(MAX_BURST - 1);
    localparam logic [c_ptr_w-1:0]   c_last_idx   = c_ptr_w'(NUM_REQ - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [c_ptr_w-1:0]   r_idx;
    logic [c_ptr_w-1:0]   r_rr_ptr;
    logic [c_ptr_w-1:0]   w_ptr_next;
    logic [c_burst_w-1:0] r_burst_cnt;
    logic                 w_win_valid;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [c_ptr_w-1:0]   w_win_idx;
    logic                 w_burst_more;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_rr_arbiter (
        .i_req     (req),
        .i_rr_ptr  (r_rr_ptr),
        .o_valid   (w_win_valid),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx)
    );

    // Another beat only while the owner still requests, holds lock and has budget left
    assign w_burst_more = lock[r_idx] && req[r_idx] && (r_burst_cnt < c_burst_last);
    assign w_ptr_next   = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

    // State register
    always_ff @(posedge clk or posedge reset_cycle) begin
        if (reset_cycle) r_state <= ARB_IDLE;
        else             r_state <= w_state_nxt;
    end

    // Next-state: arbitrate in IDLE, address then data phase, optional burst loop
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_win_valid) w_state_nxt = ARB_ADDR;
            ARB_ADDR: w_state_nxt = ARB_DATA;
            ARB_DATA: w_state_nxt = w_burst_more ? ARB_ADDR : ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    // RAM port is driven only during the address phase, from the owner's slice
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (r_state != ARB_IDLE);
        if (r_state == ARB_ADDR) begin
            mem_en    = 1'b1;
            mem_we    = we[r_idx];
            mem_addr  = addr[r_idx*ADDR_W +: ADDR_W];
            mem_wdata = wdata[r_idx*DATA_W +: DATA_W];
        end
    end

    // Grant, completion pulse, read data capture, burst count and fairness pointer
    always_ff @(posedge clk or posedge reset_cycle) begin
        if (reset_cycle) begin
            gnt         <= '0;
            ack         <= '0;
            rdata       <= '0;
            r_idx       <= '0;
            r_burst_cnt <= '0;
            r_rr_ptr    <= '0;
        end else begin
            ack <= '0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_win_valid) begin
                        gnt   <= w_win_oh;
                        r_idx <= w_win_idx;
                    end
                end
                ARB_DATA: begin
                    ack <= gnt;
                    if (!we[r_idx]) rdata <= mem_rdata;
                    if (w_burst_more) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end else begin
                        gnt         <= '0;
                        r_burst_cnt <= '0;
                        r_rr_ptr    <= w_ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_bus_arbiter                                              |
// | Purpose  : Directed self-checking bench for mem_bus_arbiter with a small  |
// |            synchronous RAM model on the memory port.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_bus_arbiter;

    localparam int NUM_REQ   = 3;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic                      clk;
    logic                      reset_cycle;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    logic [7:0] ram [256];

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .reset_cycle (reset_cycle),
        .req         (req),
        .lock        (lock),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .ack         (ack),
        .rdata       (rdata),
        .busy        (busy),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: contents reload while reset is held; ram[a] = a ^ 0x3C except ram[0x10] = 0xAB
    always @(posedge clk) begin
        if (reset_cycle) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h3C;
            ram[8'h10] <= 8'hAB;
            mem_rdata  <= '0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic apply_reset;
        reset_cycle = 1'b1;
        req = '0; lock = '0; we = '0;
        repeat (2) @(negedge clk);
        reset_cycle = 1'b0;
    endtask

    task automatic test_reset;
        reset_cycle = 1'b1;
        req = 3'b111; lock = '0; we = '0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL reset_ack: got %b want 000", ack); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        reset_cycle = 1'b0;
        req = '0;
        tick;
    endtask

    task automatic test_cpu_read;
        apply_reset;
        addr = {8'h00, 8'h00, 8'h10}; we = 3'b000; req = 3'b001;
        tick;
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL rd_gnt_c1: got %b want 001", gnt); end
        n_cmp++; if (mem_en !== 1'b1) begin n_err++; $display("FAIL rd_mem_en_c1: got %b want 1", mem_en); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rd_mem_we_c1: got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 8'h10) begin n_err++; $display("FAIL rd_mem_addr_c1: got %h want 10", mem_addr); end
        tick;
        n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL rd_ack_c2: got %b want 000", ack); end
        n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL rd_mem_en_c2: got %b want 0", mem_en); end
        tick;
        n_cmp++; if (ack !== 3'b001) begin n_err++; $display("FAIL rd_ack_c3: got %b want 001", ack); end
        n_cmp++; if (rdata !== 8'hAB) begin n_err++; $display("FAIL rd_rdata_c3: got %h want ab", rdata); end
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL rd_gnt_c3: got %b want 000", gnt); end
        req = 3'b000;
        tick;
        n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL rd_ack_c4: got %b want 000", ack); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_c4: got %b want 0", busy); end
    endtask

    task automatic test_round_robin;
        apply_reset;
        addr = {8'h03, 8'h02, 8'h01}; we = 3'b000; req = 3'b011;
        tick;
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL rr_first_gnt: got %b want 001", gnt); end
        tick; tick;
        n_cmp++; if (ack !== 3'b001) begin n_err++; $display("FAIL rr_cpu_ack: got %b want 001", ack); end
        n_cmp++; if (rdata !== 8'h3D) begin n_err++; $display("FAIL rr_cpu_rdata: got %h want 3d", rdata); end
        req = 3'b010;
        tick;
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL rr_dma_gnt: got %b want 010", gnt); end
        n_cmp++; if (mem_addr !== 8'h02) begin n_err++; $display("FAIL rr_dma_addr: got %h want 02", mem_addr); end
        tick; tick;
        n_cmp++; if (ack !== 3'b010) begin n_err++; $display("FAIL rr_dma_ack: got %b want 010", ack); end
        n_cmp++; if (rdata !== 8'h3E) begin n_err++; $display("FAIL rr_dma_rdata: got %h want 3e", rdata); end
        req = 3'b111;
        tick;
        n_cmp++; if (gnt !== 3'b100) begin n_err++; $display("FAIL rr_io_gnt: got %b want 100", gnt); end
        n_cmp++; if (mem_addr !== 8'h03) begin n_err++; $display("FAIL rr_io_addr: got %h want 03", mem_addr); end
        tick; tick;
        n_cmp++; if (ack !== 3'b100) begin n_err++; $display("FAIL rr_io_ack: got %b want 100", ack); end
        n_cmp++; if (rdata !== 8'h3F) begin n_err++; $display("FAIL rr_io_rdata: got %h want 3f", rdata); end
        req = 3'b011;
        tick;
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL rr_wrap_gnt: got %b want 001", gnt); end
        tick; tick;
        req = 3'b000;
        tick; tick;
    endtask

    task automatic test_dma_burst;
        logic [2:0] exp_ack;
        logic [2:0] exp_gnt;
        logic       exp_en;
        apply_reset;
        addr = {8'h00, 8'h04, 8'h10}; we = 3'b000; lock = 3'b010; req = 3'b010;
        tick;
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL burst_gnt_c1: got %b want 010", gnt); end
        n_cmp++; if (mem_addr !== 8'h04) begin n_err++; $display("FAIL burst_addr_c1: got %h want 04", mem_addr); end
        req = 3'b011;
        // Beats occupy cycles 1-2, 3-4, 5-6, 7-8; acks land on 3, 5, 7, 9
        for (int c = 2; c <= 9; c++) begin
            tick;
            exp_ack = (c % 2 == 1) ? 3'b010 : 3'b000;
            exp_gnt = (c <= 8) ? 3'b010 : 3'b000;
            exp_en  = (c % 2 == 1) && (c < 9);
            n_cmp++; if (ack !== exp_ack) begin n_err++; $display("FAIL burst_ack_c%0d: got %b want %b", c, ack, exp_ack); end
            n_cmp++; if (gnt !== exp_gnt) begin n_err++; $display("FAIL burst_gnt_c%0d: got %b want %b", c, gnt, exp_gnt); end
            n_cmp++; if (mem_en !== exp_en) begin n_err++; $display("FAIL burst_en_c%0d: got %b want %b", c, mem_en, exp_en); end
        end
        n_cmp++; if (rdata !== 8'h38) begin n_err++; $display("FAIL burst_rdata: got %h want 38", rdata); end
        tick;
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL burst_cpu_gnt: got %b want 001", gnt); end
        n_cmp++; if (mem_addr !== 8'h10) begin n_err++; $display("FAIL burst_cpu_addr: got %h want 10", mem_addr); end
        tick; tick;
        n_cmp++; if (ack !== 3'b001) begin n_err++; $display("FAIL burst_cpu_ack: got %b want 001", ack); end
        req = 3'b000; lock = 3'b000;
        tick; tick;
    endtask

    task automatic test_io_write;
        apply_reset;
        addr = {8'h20, 8'h00, 8'h10}; wdata = {8'h5A, 8'h00, 8'h00}; we = 3'b100; req = 3'b001;
        tick; tick; tick;
        n_cmp++; if (rdata !== 8'hAB) begin n_err++; $display("FAIL wr_pre_rdata: got %h want ab", rdata); end
        req = 3'b100;
        tick;
        n_cmp++; if (gnt !== 3'b100) begin n_err++; $display("FAIL wr_gnt: got %b want 100", gnt); end
        n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL wr_mem_we_c1: got %b want 1", mem_we); end
        n_cmp++; if (mem_addr !== 8'h20) begin n_err++; $display("FAIL wr_mem_addr: got %h want 20", mem_addr); end
        n_cmp++; if (mem_wdata !== 8'h5A) begin n_err++; $display("FAIL wr_mem_wdata: got %h want 5a", mem_wdata); end
        tick;
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL wr_mem_we_c2: got %b want 0", mem_we); end
        tick;
        n_cmp++; if (ack !== 3'b100) begin n_err++; $display("FAIL wr_ack: got %b want 100", ack); end
        n_cmp++; if (rdata !== 8'hAB) begin n_err++; $display("FAIL wr_rdata_hold: got %h want ab", rdata); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL wr_mem_we_c3: got %b want 0", mem_we); end
        req = 3'b000;
        tick;
        n_cmp++; if (ram[8'h20] !== 8'h5A) begin n_err++; $display("FAIL wr_ram: got %h want 5a", ram[8'h20]); end
        we = 3'b000;
    endtask

    task automatic test_reset_mid;
        apply_reset;
        addr = {8'h03, 8'h02, 8'h01}; we = 3'b000; req = 3'b111;
        tick;
        n_cmp++; if (mem_en !== 1'b1) begin n_err++; $display("FAIL mid_pre_en: got %b want 1", mem_en); end
        #2 reset_cycle = 1'b1;
        #1;
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL mid_gnt: got %b want 000", gnt); end
        n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL mid_mem_en: got %b want 0", mem_en); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL mid_ack: got %b want 000", ack); end
        tick; tick;
        n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL mid_ack_held: got %b want 000", ack); end
        reset_cycle = 1'b0;
        tick;
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL mid_regnt: got %b want 001", gnt); end
        tick; tick;
        n_cmp++; if (ack !== 3'b001) begin n_err++; $display("FAIL mid_ack_after: got %b want 001", ack); end
        req = 3'b000;
        tick; tick;
    endtask

    task automatic test_lock_drop;
        apply_reset;
        addr = {8'h00, 8'h00, 8'h10}; we = 3'b000; lock = 3'b001; req = 3'b001;
        tick;
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL drop_gnt: got %b want 001", gnt); end
        tick;
        req = 3'b000;
        tick;
        n_cmp++; if (ack !== 3'b001) begin n_err++; $display("FAIL drop_ack: got %b want 001", ack); end
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL drop_gnt_after: got %b want 000", gnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy: got %b want 0", busy); end
        n_cmp++; if (rdata !== 8'hAB) begin n_err++; $display("FAIL drop_rdata: got %h want ab", rdata); end
        tick;
        n_cmp++; if (ack !== 3'b000) begin n_err++; $display("FAIL drop_ack_once: got %b want 000", ack); end
        n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL drop_no_beat: got %b want 0", mem_en); end
        lock = 3'b000;
    endtask

    initial begin
        reset_cycle = 1'b1;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        test_reset;
        test_cpu_read;
        test_round_robin;
        test_dma_burst;
        test_io_write;
        test_reset_mid;
        test_lock_drop;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
